// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: RV32I load/store
// funct3 encodings, controller state type, error codes, and a legality helper.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_FUNCT3   = 2'd1;
  localparam logic [1:0] ERR_MISALIGN = 2'd2;
  localparam logic [1:0] ERR_RANGE    = 2'd3;

  // Unsigned widths exist only for loads.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = ~we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for loads and stores.
// Ports:
//   funct3_i   access width/signedness
//   addr_lo_i  byte offset within the word
//   wdata_i    right-aligned store data
//   rword_i    word read from the array
//   be_o       per-byte write enable
//   wdata_o    store data replicated across lanes
//   rdata_o    extracted and extended load data
//   misalign_o access not naturally aligned
module dmem_lane_align (
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_lo_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o,
  output logic        misalign_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel   = rword_i[{addr_lo_i, 3'b000} +: 8];
    half_sel   = rword_i[{addr_lo_i[1], 4'b0000} +: 16];
    be_o       = '0;
    wdata_o    = wdata_i;
    rdata_o    = '0;
    misalign_o = 1'b0;
    // funct3[2] marks the unsigned load variants.
    case (funct3_i[1:0])
      2'b00: begin
        be_o    = 4'b0001 << addr_lo_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{byte_sel[7] & ~funct3_i[2]}}, byte_sel};
      end
      2'b01: begin
        be_o       = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o    = {2{wdata_i[15:0]}};
        rdata_o    = {{16{half_sel[15] & ~funct3_i[2]}}, half_sel};
        misalign_o = addr_lo_i[0];
      end
      2'b10: begin
        be_o       = '1;
        rdata_o    = rword_i;
        misalign_o = |addr_lo_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked fixed-latency data memory for the core's load/store path.
// Ports:
//   clk, reset              clock, async active-high reset
//   req_valid / req_ready   request handshake
//   req_we, req_addr, req_funct3, req_wdata   request fields
//   rsp_valid               one-cycle response pulse
//   rsp_rdata, rsp_err      response data/error, held until next response
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam bit         NO_WAIT  = (LATENCY == 0);
  localparam logic [3:0] CNT_INIT = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic        we_q;
  logic [31:0] addr_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic        req_ready_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic [31:0] mem [DEPTH];

  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [2:0]        acc_f3;
  logic [31:0]       acc_wdata;
  logic [ADDR_W-1:0] word_idx;
  logic [3:0]        lane_be;
  logic [31:0]       lane_wdata;
  logic [31:0]       lane_rdata;
  logic              lane_misalign;
  logic [1:0]        err_code;
  logic              acc_err;
  logic              accept;
  logic              commit;

  // With zero latency the access happens on the accept edge, so the live
  // request fields are used instead of the captured copies.
  always_comb begin
    if (state_q == IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_f3    = req_funct3;
      acc_wdata = req_wdata;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_f3    = f3_q;
      acc_wdata = wdata_q;
    end
  end

  assign word_idx = acc_addr[ADDR_W+1:2];
  assign accept   = (state_q == IDLE) && req_valid;
  assign commit   = (accept && NO_WAIT) || ((state_q == WAIT) && (cnt_q == '0));

  dmem_lane_align u_align (
    .funct3_i   (acc_f3),
    .addr_lo_i  (acc_addr[1:0]),
    .wdata_i    (acc_wdata),
    .rword_i    (mem[word_idx]),
    .be_o       (lane_be),
    .wdata_o    (lane_wdata),
    .rdata_o    (lane_rdata),
    .misalign_o (lane_misalign)
  );

  always_comb begin
    err_code = ERR_NONE;
    if (!f3_legal(acc_f3, acc_we))        err_code = ERR_FUNCT3;
    else if (lane_misalign)               err_code = ERR_MISALIGN;
    else if (acc_addr[31:ADDR_W+2] != '0) err_code = ERR_RANGE;
  end

  assign acc_err = (err_code != ERR_NONE);

  // Array has no reset; a reset coinciding with the commit edge blocks the write.
  always_ff @(posedge clk) begin
    if (commit && acc_we && !acc_err && !reset) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lane_be[i]) mem[word_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      f3_q        <= '0;
      wdata_q     <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            f3_q        <= req_funct3;
            wdata_q     <= req_wdata;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            state_q     <= NO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) state_q <= RESP;
          else             cnt_q   <= cnt_q - 4'd1;
        end
        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
      if (commit) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= acc_err;
        rsp_rdata_q <= (acc_err || acc_we) ? '0 : lane_rdata;
      end
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;
  import dmem_pkg::*;

  localparam int NI = 3;
  localparam int LAT_TAB [NI] = '{0, 1, 15};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset      [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_we     [NI];
  logic [31:0] req_addr   [NI];
  logic [2:0]  req_funct3 [NI];
  logic [31:0] req_wdata  [NI];
  logic        rsp_valid  [NI];
  logic [31:0] rsp_rdata  [NI];
  logic        rsp_err    [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    dmem_ctrl #(.ADDR_W(8), .LATENCY(LAT_TAB[g])) u_dut (
      .clk        (clk),
      .reset      (reset[g]),
      .req_valid  (req_valid[g]),
      .req_ready  (req_ready[g]),
      .req_we     (req_we[g]),
      .req_addr   (req_addr[g]),
      .req_funct3 (req_funct3[g]),
      .req_wdata  (req_wdata[g]),
      .rsp_valid  (rsp_valid[g]),
      .rsp_rdata  (rsp_rdata[g]),
      .rsp_err    (rsp_err[g])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  // Byte-addressed reference memory, 1 KiB per instance (ADDR_W = 8).
  logic [7:0] mm [NI][1024];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Returns {err, rdata}; applies legal stores to the reference memory.
  function automatic logic [32:0] model(input int inst, input logic we, input logic [31:0] addr,
                                        input logic [2:0] f3, input logic [31:0] wd);
    int size;
    bit sgn;
    logic [31:0] v;
    size = 0;
    sgn  = 0;
    case (f3)
      3'b000: begin size = 1; sgn = 1; end
      3'b001: begin size = 2; sgn = 1; end
      3'b010: size = 4;
      3'b100: if (!we) size = 1;
      3'b101: if (!we) size = 2;
      default: size = 0;
    endcase
    if (size == 0) return {1'b1, 32'h0};
    if (addr >= 32'd1024) return {1'b1, 32'h0};
    if ((addr % size) != 0) return {1'b1, 32'h0};
    if (we) begin
      for (int i = 0; i < size; i++) mm[inst][addr + i] = wd[8*i +: 8];
      return 33'h0;
    end
    v = '0;
    for (int i = 0; i < size; i++) v = v | (32'(mm[inst][addr + i]) << (8*i));
    if (sgn && size < 4 && v[8*size-1]) v = v | ~((32'h1 << (8*size)) - 32'h1);
    return {1'b0, v};
  endfunction

  // One transaction: drive, check latency cycle by cycle, inject ignored
  // req_valid pulses while busy, and check held outputs afterwards.
  task automatic do_op(input int inst, input logic we, input logic [31:0] addr,
                       input logic [2:0] f3, input logic [31:0] wd, output logic [31:0] got);
    logic [32:0] e;
    int lat;
    lat = LAT_TAB[inst];
    got = 'x;
    @(negedge clk);
    chk($sformatf("i%0d ready_before_req", inst), req_ready[inst], 32'h1);
    req_valid[inst]  = 1'b1;
    req_we[inst]     = we;
    req_addr[inst]   = addr;
    req_funct3[inst] = f3;
    req_wdata[inst]  = wd;
    e = model(inst, we, addr, f3, wd);
    @(negedge clk);
    for (int k = 1; k <= lat + 2; k++) begin
      if (k == lat + 2) begin
        req_valid[inst] = 1'b0;
        chk($sformatf("i%0d valid_after a=%h", inst, addr), rsp_valid[inst], 32'h0);
        chk($sformatf("i%0d ready_after a=%h", inst, addr), req_ready[inst], 32'h1);
        chk($sformatf("i%0d rdata_held a=%h", inst, addr), rsp_rdata[inst], e[31:0]);
        chk($sformatf("i%0d err_held a=%h", inst, addr), rsp_err[inst], {31'h0, e[32]});
      end else begin
        if (k == lat + 1) begin
          chk($sformatf("i%0d rsp_valid a=%h", inst, addr), rsp_valid[inst], 32'h1);
          chk($sformatf("i%0d rdata we=%0d f3=%0d a=%h", inst, we, f3, addr), rsp_rdata[inst], e[31:0]);
          chk($sformatf("i%0d err we=%0d f3=%0d a=%h", inst, we, f3, addr), rsp_err[inst], {31'h0, e[32]});
          got = rsp_rdata[inst];
        end else begin
          chk($sformatf("i%0d early_valid k=%0d", inst, k), rsp_valid[inst], 32'h0);
        end
        chk($sformatf("i%0d ready_busy k=%0d", inst, k), req_ready[inst], 32'h0);
        req_valid[inst]  = 1'($urandom_range(0, 1));
        req_we[inst]     = 1'($urandom);
        req_addr[inst]   = 32'($urandom_range(0, 255));
        req_funct3[inst] = 3'($urandom);
        req_wdata[inst]  = $urandom;
      end
      if (k < lat + 2) @(negedge clk);
    end
  endtask

  initial begin
    logic [31:0] got;
    logic [31:0] pre8;
    logic [31:0] a;
    for (int i = 0; i < NI; i++) begin
      reset[i] = 1'b1; req_valid[i] = 1'b0; req_we[i] = 1'b0;
      req_addr[i] = '0; req_funct3[i] = '0; req_wdata[i] = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("i%0d reset ready", i), req_ready[i], 32'h1);
      chk($sformatf("i%0d reset valid", i), rsp_valid[i], 32'h0);
      chk($sformatf("i%0d reset rdata", i), rsp_rdata[i], 32'h0);
      chk($sformatf("i%0d reset err", i), rsp_err[i], 32'h0);
      reset[i] = 1'b0;
    end

    // Fill the first 64 words of each instance so later loads are defined.
    for (int i = 0; i < NI; i++)
      for (int w = 0; w < 64; w++) do_op(i, 1'b1, 32'(w * 4), F3_W, $urandom, got);

    // Directed sequence at LATENCY=1.
    do_op(1, 1'b1, 32'h0, F3_W, 32'hFFFFFF00, got);
    do_op(1, 1'b0, 32'h0, F3_W, 32'h0, got);
    chk("plan lw0", got, 32'hFFFFFF00);
    do_op(1, 1'b1, 32'h4, F3_W, 32'h11223344, got);
    do_op(1, 1'b1, 32'h5, F3_B, 32'h000000AB, got);
    do_op(1, 1'b0, 32'h4, F3_W, 32'h0, got);
    chk("plan sb word", got, 32'h1122AB44);
    do_op(1, 1'b0, 32'h5, F3_B, 32'h0, got);
    chk("plan lb", got, 32'hFFFFFFAB);
    do_op(1, 1'b0, 32'h5, F3_BU, 32'h0, got);
    chk("plan lbu", got, 32'h000000AB);
    do_op(1, 1'b1, 32'h6, F3_H, 32'h00008001, got);
    do_op(1, 1'b0, 32'h6, F3_H, 32'h0, got);
    chk("plan lh", got, 32'hFFFF8001);
    do_op(1, 1'b0, 32'h6, F3_HU, 32'h0, got);
    chk("plan lhu", got, 32'h00008001);
    do_op(1, 1'b0, 32'h4, F3_W, 32'h0, got);
    chk("plan sh word", got, 32'h8001AB44);
    do_op(1, 1'b0, 32'h2, F3_W, 32'h0, got);
    chk("plan lw mis err", rsp_err[1], 32'h1);
    chk("plan lw mis data", got, 32'h0);
    do_op(1, 1'b1, 32'h3, F3_H, 32'h0000FFFF, got);
    chk("plan sh mis err", rsp_err[1], 32'h1);
    do_op(1, 1'b0, 32'h400, F3_W, 32'h0, got);
    chk("plan range err", rsp_err[1], 32'h1);
    chk("plan range data", got, 32'h0);
    do_op(1, 1'b0, 32'h0, F3_W, 32'h0, got);
    chk("plan nowrite w0", got, 32'hFFFFFF00);
    do_op(1, 1'b0, 32'h4, F3_W, 32'h0, got);
    chk("plan nowrite w1", got, 32'h8001AB44);
    do_op(1, 1'b1, 32'h8, 3'b100, 32'h12345678, got);
    chk("plan sbu err", rsp_err[1], 32'h1);

    // Reset in the middle of a LATENCY=15 store: dropped, no write.
    pre8 = {mm[2][11], mm[2][10], mm[2][9], mm[2][8]};
    @(negedge clk);
    req_valid[2] = 1'b1; req_we[2] = 1'b1; req_addr[2] = 32'h8;
    req_funct3[2] = F3_W; req_wdata[2] = ~pre8;
    @(negedge clk);
    req_valid[2] = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("rst pre valid", rsp_valid[2], 32'h0);
      chk("rst pre ready", req_ready[2], 32'h0);
      @(negedge clk);
    end
    #2 reset[2] = 1'b1;
    #1;
    chk("rst async ready", req_ready[2], 32'h1);
    chk("rst async valid", rsp_valid[2], 32'h0);
    chk("rst async rdata", rsp_rdata[2], 32'h0);
    repeat (2) @(negedge clk);
    reset[2] = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk("rst post valid", rsp_valid[2], 32'h0);
      chk("rst post ready", req_ready[2], 32'h1);
    end
    do_op(2, 1'b0, 32'h8, F3_W, 32'h0, got);
    chk("rst no write", got, pre8);

    // Random traffic against the reference model.
    for (int i = 0; i < NI; i++) begin
      for (int n = 0; n < 60; n++) begin
        if ($urandom_range(0, 9) == 0) a = 32'h400 + 32'($urandom_range(0, 4095));
        else                           a = 32'($urandom_range(0, 255));
        do_op(i, 1'($urandom), a, 3'($urandom), $urandom, got);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
